cla_multiword_add_ctrl: RTL and testbench
=========================================

CLA_MULTIWORD_ADD_CTRL -- requirements
Module: cla_multiword_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the operand width W = 4*NIBBLES bits, with legal range 2..8.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: requests an addition; SHALL be sampled only in IDLE.
REQ-005 Port a, input, W bits: operand A.
REQ-006 Port b, input, W bits: operand B.
REQ-007 Port cin, input, 1 bit: carry into nibble 0.
REQ-008 Port busy, output, 1 bit: high while the operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 Port sum, output, W bits: result.
REQ-011 Port cout, output, 1 bit: carry out of the MSB nibble.
REQ-012 Port ovf, output, 1 bit: two's-complement overflow flag.

Function
REQ-013 The block SHALL add a + b + cin with one shared 4-bit carry-lookahead adder, processing one nibble per cycle, LSB nibble first.
REQ-014 The FSM SHALL have three states, IDLE, ADD and DONE, with these transitions:
- IDLE to ADD on start=1.
- ADD to DONE after nibble NIBBLES-1 is processed.
- DONE to IDLE unconditionally.
REQ-015 On accepting start (IDLE, start=1, rising edge E0), the block SHALL latch a, b and cin, clear the nibble index and clear sum.
REQ-016 In ADD, nibble i SHALL be presented to the CLA, with Cin taken from the carry register (latched cin when i=0). At edge E(i+1) it SHALL write Sum into sum[4i+3:4i] and Cout into the carry register.
REQ-017 busy SHALL be 1 exactly in ADD, i.e. for NIBBLES cycles after E0.
REQ-018 done SHALL be 1 exactly in DONE, i.e. for one cycle starting at edge E(NIBBLES), giving a start-to-done latency of NIBBLES+1 edges.
REQ-019 sum, cout and ovf SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-020 cout SHALL equal the carry register after the final nibble.
REQ-021 ovf SHALL equal (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using the latched operands.
REQ-022 start SHALL be ignored in ADD and DONE, with no re-latch and no queuing.
REQ-023 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted, so back-to-back operations are separated by exactly one IDLE cycle.
REQ-024 Changes on a, b and cin after E0 SHALL NOT affect the result in progress.
REQ-025 The result SHALL be exact modulo 2^W for all operands, including full-carry-chain cases such as all-ones + 1.

Reset
REQ-026 When rst=1 at a rising edge, the FSM SHALL go to IDLE, and busy, done, sum, cout, ovf, the carry register and the nibble index SHALL all become 0.
REQ-027 Reset asserted mid-operation (ADD or DONE) SHALL abort the operation with no done pulse, and a start in the first cycle after rst deasserts SHALL be accepted.
REQ-028 rst SHALL take priority over start when both are high at the same edge.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration (IDLE, ADD, DONE) and the nibble-width constant 4.
REQ-030 The block SHALL instantiate exactly one sub-module, carry_lookahead_adder_4bit, with ports A, B, Cin, Sum and Cout. No other adder logic is permitted in the datapath.
REQ-031 The block SHALL contain the operand/carry/result registers, the nibble counter (width $clog2(NIBBLES)) and the FSM, with no combinational path from inputs to outputs.

Verification
REQ-032 With NIBBLES=4, a=0x0000, b=0x0000, cin=0 and start pulsed: busy=1 for 4 cycles, then done=1 for 1 cycle with sum=0x0000, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; and a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-034 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; and a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
REQ-035 Start with a=0x00F0, b=0x0010, then pulse start with a=0x1111, b=0x1111 during busy -> result sum=0x0100; the second request is ignored and done pulses once.
REQ-036 Assert rst for one cycle during the second ADD cycle -> busy=0, sum=0, no done. Start 0x000A+0x0005 on the next cycle -> sum=0x000F after 5 edges.
REQ-037 Issue back-to-back starts held high continuously -> each done is followed by one IDLE cycle, then busy. Every result SHALL match a+b+cin in the reference model.

Source files
------------

// File: rtl/cla_multiword_add_ctrl_pkg.sv
// Shared definitions for the multi-word carry-lookahead adder controller.
//   - FSM state encoding (IDLE, ADD, DONE)
//   - nibble width handled per cycle by the shared 4-bit adder
package cla_multiword_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/carry_lookahead_adder_4bit.sv
// 4-bit carry-lookahead adder, purely combinational.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out of bit 3
module carry_lookahead_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is expanded directly from generate/propagate terms so no
  // carry depends on a previous carry output.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Serial multi-word adder: computes a + b + cin one nibble per cycle, LSB
// nibble first, through a single shared 4-bit carry-lookahead adder.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request an addition (sampled only in IDLE)
//   a, b  : W-bit operands, W = 4*NIBBLES
//   cin   : carry into nibble 0
//   busy  : high while nibbles are being added
//   done  : one-cycle pulse, result valid
//   sum   : W-bit result (held until the next accepted start)
//   cout  : carry out of the MSB nibble
//   ovf   : two's-complement overflow
module cla_multiword_add_ctrl
  import cla_multiword_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic             cout_q;
  logic             ovf_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  logic             last_nib;

  assign a_nib    = a_q[idx*NIB_W +: NIB_W];
  assign b_nib    = b_q[idx*NIB_W +: NIB_W];
  assign last_nib = (idx == LAST_IDX);

  // The carry register is loaded with cin on start, so nibble 0 sees the
  // external carry-in and later nibbles see the previous nibble's carry.
  carry_lookahead_adder_4bit u_cla (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ADD;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            idx     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ST_ADD: begin
          sum_q[idx*NIB_W +: NIB_W] <= nib_sum;
          carry_q                   <= nib_cout;
          if (last_nib) begin
            state  <= ST_DONE;
            cout_q <= nib_cout;
            // Overflow uses the MSB of the final nibble as it is written.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (nib_sum[NIB_W-1] != a_q[W-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_ADD);
  assign done = (state == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Scoreboard bench for cla_multiword_add_ctrl (NIBBLES = 4, W = 16).
module tb_cla_multiword_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  cla_multiword_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the full operands.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv);
    exp_t        e;
    logic [16:0] t;
    int          sa;
    int          sb;
    int          s;
    t  = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    sa = $signed(av);
    sb = $signed(bv);
    s  = sa + sb + (cv ? 1 : 0);
    e.sum  = t[15:0];
    e.cout = t[16];
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with sum=0x%0h, expected no result", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum",  {16'd0, sum},  {16'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
        chk("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
      end
    end
  end

  // One operation: start is driven at a negedge in IDLE (accepted at the next
  // edge E0). Busy must be seen after E0..E3, done after E4, idle after E5.
  // Operands are scrambled after E0; hold keeps start high, poke re-requests
  // with different operands during busy.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input bit hold, input bit poke,
                        input bit now);
    int bad;
    bad = 0;
    if (!now) begin
      @(negedge clk);
      chk("idle_before_start", {30'd0, busy, done}, 32'd0);
    end
    a = av; b = bv; cin = cv; start = 1'b1;
    q.push_back(model(av, bv, cv));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (busy !== (n < 4) || done !== (n == 4)) bad++;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      if (poke && n == 1) begin
        a = 16'h1111; b = 16'h1111; start = 1'b1;
      end else if (!hold) begin
        start = 1'b0;
      end
    end
    chk("busy_done_sequence", bad, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {12'd0, busy, done, cout, ovf, sum}, 32'd0);
    rst = 1'b0;

    // Directed corner cases.
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort with reset in the second ADD cycle, then restart immediately.
    @(negedge clk);
    a = 16'h5555; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum",  {16'd0, sum},  32'd0);
    rst = 1'b0;
    run_op(16'h000A, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    chk("rst_over_start", {30'd0, busy, done}, 32'd0);
    rst = 1'b0; start = 1'b0;

    // Back-to-back with start held high throughout.
    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);

    // Random mix of isolated and held operations.
    for (int i = 0; i < 30; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), (i % 3) != 0,
             1'b0, 1'b0);

    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
